// File: rtl/step_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg -- shared definitions for the step sequencer slice.
//
// Contents:
//   SEQ_DEPTH    default number of pattern steps
//   KEY_W        default keycode width (0 means "no key")
//   seq_state_t  sequencer mode: IDLE, RECORD, PLAY
// ---------------------------------------------------------------------------
package synth_pkg;

  localparam int unsigned SEQ_DEPTH = 8;
  localparam int unsigned KEY_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } seq_state_t;

endpackage : synth_pkg

// File: rtl/step_sequencer_mem.sv
// ---------------------------------------------------------------------------
// seq_mem -- pattern storage for the step sequencer.
//
// DEPTH x KEY_W register file with a single synchronous write port and a
// single combinational read port. Asynchronous reset clears every entry,
// so a freshly reset sequencer never replays stale notes.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, clears all entries
//   we_i     in   write enable (caller already qualifies with block enable)
//   waddr_i  in   write address
//   wdata_i  in   write data (0 stores a rest)
//   raddr_i  in   read address
//   rdata_o  out  combinational read data at raddr_i
// ---------------------------------------------------------------------------
module seq_mem
  import synth_pkg::*;
#(
  parameter int unsigned DEPTH = synth_pkg::SEQ_DEPTH,
  parameter int unsigned KEY_W = synth_pkg::KEY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [KEY_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [KEY_W-1:0]         rdata_o
);

  logic [KEY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : seq_mem

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer -- keypad step sequencer (record / play a short pattern).
//
// In RECORD each new key press (or a play strobe, meaning "rest") is appended
// to the pattern until it is full. In PLAY the pattern is stepped on each
// tempo tick, wrapping at the recorded length. A key held on the keypad always
// overrides the pattern on keycode_o. en low freezes everything and mutes the
// output.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   en           in   block enable; low freezes all state and mutes output
//   keycode_i    in   live keycode from keypad encoder (0 = no key)
//   key_edge_i   in   one-cycle strobe: new key press
//   rec_edge_i   in   one-cycle strobe: record toggle
//   play_edge_i  in   one-cycle strobe: play/stop, or rest while recording
//   tick_i       in   one-cycle tempo strobe
//   keycode_o    out  keycode to the frequency divider
//   step_o       out  current playback step (0 outside PLAY)
//   len_o        out  recorded pattern length, 0..SEQ_DEPTH
//   recording_o  out  high in RECORD
//   playing_o    out  high in PLAY
// ---------------------------------------------------------------------------
module step_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned SEQ_DEPTH = synth_pkg::SEQ_DEPTH,
  parameter int unsigned KEY_W     = synth_pkg::KEY_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [KEY_W-1:0]               keycode_i,
  input  logic                           key_edge_i,
  input  logic                           rec_edge_i,
  input  logic                           play_edge_i,
  input  logic                           tick_i,
  output logic [KEY_W-1:0]               keycode_o,
  output logic [$clog2(SEQ_DEPTH)-1:0]   step_o,
  output logic [$clog2(SEQ_DEPTH+1)-1:0] len_o,
  output logic                           recording_o,
  output logic                           playing_o
);

  localparam int unsigned STEP_W = $clog2(SEQ_DEPTH);
  localparam int unsigned LEN_W  = $clog2(SEQ_DEPTH + 1);

  seq_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic              mem_we;
  logic [STEP_W-1:0] mem_waddr;
  logic [KEY_W-1:0]  mem_wdata;
  logic [KEY_W-1:0]  mem_rdata;

  logic              full;
  logic              key_valid;
  logic [LEN_W-1:0]  step_inc;

  assign full      = (len_q >= LEN_W'(SEQ_DEPTH));
  assign key_valid = (keycode_i != '0);
  // Widened so step+1 can be compared against len even when len == SEQ_DEPTH.
  assign step_inc  = LEN_W'(step_q) + LEN_W'(1);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      step_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      len_q   <= len_d;
      step_q  <= step_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, counters and memory write control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    step_d    = step_q;
    mem_we    = 1'b0;
    mem_waddr = len_q[STEP_W-1:0];
    mem_wdata = '0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          // Record toggle has priority over a simultaneous play strobe.
          if (rec_edge_i) begin
            state_d = RECORD;
            len_d   = '0;
            step_d  = '0;
          end else if (play_edge_i && (len_q != '0)) begin
            state_d = PLAY;
            step_d  = '0;
          end
        end

        RECORD: begin
          // Leaving RECORD swallows any key/rest strobe in the same cycle.
          if (rec_edge_i) begin
            state_d = IDLE;
          end else if (!full) begin
            if (key_edge_i && key_valid) begin
              mem_we    = 1'b1;
              mem_wdata = keycode_i;
              len_d     = len_q + LEN_W'(1);
            end else if (play_edge_i) begin
              mem_we    = 1'b1;
              mem_wdata = '0;
              len_d     = len_q + LEN_W'(1);
            end
          end
        end

        PLAY: begin
          // Stop wins over a coincident tick; rec_edge_i is ignored here.
          if (play_edge_i) begin
            state_d = IDLE;
            step_d  = '0;
          end else if (tick_i) begin
            step_d = (step_inc == len_q) ? '0 : step_inc[STEP_W-1:0];
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pattern memory
  // -------------------------------------------------------------------------
  seq_mem #(
    .DEPTH (SEQ_DEPTH),
    .KEY_W (KEY_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (step_q),
    .rdata_o (mem_rdata)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    keycode_o = '0;
    if (en) begin
      if (key_valid) begin
        keycode_o = keycode_i;
      end else if (state_q == PLAY) begin
        keycode_o = mem_rdata;
      end
    end
  end

  assign step_o      = (state_q == PLAY) ? step_q : '0;
  assign len_o       = len_q;
  assign recording_o = (state_q == RECORD);
  assign playing_o   = (state_q == PLAY);

endmodule : step_sequencer

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer -- self-checking bench for step_sequencer.
// Directed scenarios check against fixed expected values; the random phase
// checks every output against a behavioural pattern model.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] keycode_i = '0;
  logic       key_edge_i = 1'b0;
  logic       rec_edge_i = 1'b0;
  logic       play_edge_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [3:0] keycode_o;
  logic [2:0] step_o;
  logic [3:0] len_o;
  logic       recording_o;
  logic       playing_o;

  int tests = 0;
  int fails = 0;

  // Behavioural model: mode 0 = idle, 1 = recording, 2 = playing.
  int m_mode;
  int m_len;
  int m_step;
  int m_mem [8];

  step_sequencer #(
    .SEQ_DEPTH (8),
    .KEY_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .keycode_i   (keycode_i),
    .key_edge_i  (key_edge_i),
    .rec_edge_i  (rec_edge_i),
    .play_edge_i (play_edge_i),
    .tick_i      (tick_i),
    .keycode_o   (keycode_o),
    .step_o      (step_o),
    .len_o       (len_o),
    .recording_o (recording_o),
    .playing_o   (playing_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0;
    m_len  = 0;
    m_step = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
  endtask

  task automatic model_step(input bit e, input int k, input bit ke, input bit re,
                            input bit pe, input bit tk);
    if (!e) return;
    case (m_mode)
      0: begin
        if (re) begin
          m_mode = 1; m_len = 0; m_step = 0;
        end else if (pe && m_len > 0) begin
          m_mode = 2; m_step = 0;
        end
      end
      1: begin
        if (re) m_mode = 0;
        else if (m_len < 8 && ke && k != 0) begin
          m_mem[m_len] = k; m_len++;
        end else if (m_len < 8 && pe) begin
          m_mem[m_len] = 0; m_len++;
        end
      end
      default: begin
        if (pe) begin
          m_mode = 0; m_step = 0;
        end else if (tk) begin
          m_step = (m_step + 1) % m_len;
        end
      end
    endcase
  endtask

  function automatic int exp_key(input bit e, input int k);
    if (!e) return 0;
    if (k != 0) return k;
    return (m_mode == 2) ? m_mem[m_step] : 0;
  endfunction

  // One clock cycle with the given inputs; strobes drop after the edge.
  task automatic drive(input bit e, input int k, input bit ke, input bit re,
                       input bit pe, input bit tk);
    en = e; keycode_i = 4'(k);
    key_edge_i = ke; rec_edge_i = re; play_edge_i = pe; tick_i = tk;
    @(posedge clk);
    model_step(e, k, ke, re, pe, tk);
    #1;
    key_edge_i = 1'b0; rec_edge_i = 1'b0; play_edge_i = 1'b0; tick_i = 1'b0;
  endtask

  task automatic nop();          drive(1, 0, 0, 0, 0, 0); endtask
  task automatic press(input int k); drive(1, k, 1, 0, 0, 0); endtask
  task automatic rec();          drive(1, 0, 0, 1, 0, 0); endtask
  task automatic play();         drive(1, 0, 0, 0, 1, 0); endtask
  task automatic tick();         drive(1, 0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    en = 1'b1; keycode_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; keycode_i = '0;
    #2;
    tests++; if (len_o !== 4'd0) begin fails++; $display("FAIL reset_len got %0d exp 0", len_o); end
    tests++; if (step_o !== 3'd0) begin fails++; $display("FAIL reset_step got %0d exp 0", step_o); end
    tests++; if (recording_o !== 1'b0 || playing_o !== 1'b0) begin fails++;
      $display("FAIL reset_mode got rec=%0b play=%0b exp 0 0", recording_o, playing_o); end
    tests++; if (keycode_o !== 4'd0) begin fails++; $display("FAIL reset_key got %0d exp 0", keycode_o); end
    keycode_i = 4'd5; #1;
    tests++; if (keycode_o !== 4'd5) begin fails++; $display("FAIL reset_live_key got %0d exp 5", keycode_o); end
    en = 1'b0; #1;
    tests++; if (keycode_o !== 4'd0) begin fails++; $display("FAIL reset_en0_key got %0d exp 0", keycode_o); end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; keycode_i = '0;
    model_reset();
  endtask

  task automatic test_basic();
    int ek [4] = '{3, 5, 7, 3};
    int es [4] = '{0, 1, 2, 0};
    do_reset();
    rec(); press(3); press(5); press(7); rec(); play();
    tests++; if (len_o !== 4'd3) begin fails++; $display("FAIL basic_len got %0d exp 3", len_o); end
    tests++; if (playing_o !== 1'b1) begin fails++; $display("FAIL basic_playing got %0b exp 1", playing_o); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      tests++; if (keycode_o !== 4'(ek[i]) || step_o !== 3'(es[i])) begin fails++;
        $display("FAIL basic_step%0d got key=%0d step=%0d exp key=%0d step=%0d",
                 i, keycode_o, step_o, ek[i], es[i]); end
    end
  endtask

  task automatic test_full();
    do_reset();
    rec();
    for (int k = 1; k <= 9; k++) press(k);
    tests++; if (len_o !== 4'd8) begin fails++; $display("FAIL full_len got %0d exp 8", len_o); end
    tests++; if (recording_o !== 1'b1) begin fails++; $display("FAIL full_rec got %0b exp 1", recording_o); end
    play(); // rest strobe while full must be dropped
    tests++; if (len_o !== 4'd8) begin fails++; $display("FAIL full_rest_len got %0d exp 8", len_o); end
    rec(); play();
    for (int i = 0; i <= 8; i++) begin
      tests++; if (keycode_o !== 4'((i % 8) + 1) || step_o !== 3'(i % 8)) begin fails++;
        $display("FAIL full_play%0d got key=%0d step=%0d exp key=%0d step=%0d",
                 i, keycode_o, step_o, (i % 8) + 1, i % 8); end
      tick();
    end
  endtask

  task automatic test_rest();
    int ek [3] = '{4, 0, 6};
    do_reset();
    rec(); press(4); play(); press(6); rec(); play();
    tests++; if (len_o !== 4'd3) begin fails++; $display("FAIL rest_len got %0d exp 3", len_o); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      tests++; if (keycode_o !== 4'(ek[i])) begin fails++;
        $display("FAIL rest_step%0d got %0d exp %0d", i, keycode_o, ek[i]); end
    end
  endtask

  task automatic test_override();
    do_reset();
    rec(); press(2); press(8); press(3); rec(); play(); tick();
    tests++; if (keycode_o !== 4'd8 || step_o !== 3'd1) begin fails++;
      $display("FAIL ovr_step1 got key=%0d step=%0d exp key=8 step=1", keycode_o, step_o); end
    drive(1, 9, 0, 0, 0, 0);
    tests++; if (keycode_o !== 4'd9) begin fails++; $display("FAIL ovr_live got %0d exp 9", keycode_o); end
    nop();
    tests++; if (keycode_o !== 4'd8) begin fails++; $display("FAIL ovr_release got %0d exp 8", keycode_o); end
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    tests++; if (keycode_o !== 4'd0) begin fails++; $display("FAIL ovr_en0_key got %0d exp 0", keycode_o); end
    tests++; if (step_o !== 3'd1 || playing_o !== 1'b1 || len_o !== 4'd3) begin fails++;
      $display("FAIL ovr_en0_hold got step=%0d play=%0b len=%0d exp 1 1 3", step_o, playing_o, len_o); end
    nop();
    tests++; if (keycode_o !== 4'd8 || step_o !== 3'd1) begin fails++;
      $display("FAIL ovr_resume got key=%0d step=%0d exp key=8 step=1", keycode_o, step_o); end
  endtask

  task automatic test_collisions();
    // Continues from PLAY at step 1, len 3.
    drive(1, 0, 0, 0, 1, 1);
    tests++; if (playing_o !== 1'b0 || step_o !== 3'd0 || len_o !== 4'd3) begin fails++;
      $display("FAIL col_tick_stop got play=%0b step=%0d len=%0d exp 0 0 3", playing_o, step_o, len_o); end
    drive(1, 0, 0, 1, 1, 0);
    tests++; if (recording_o !== 1'b1 || playing_o !== 1'b0 || len_o !== 4'd0) begin fails++;
      $display("FAIL col_rec_play got rec=%0b play=%0b len=%0d exp 1 0 0", recording_o, playing_o, len_o); end
    drive(1, 5, 1, 1, 0, 0);
    tests++; if (recording_o !== 1'b0 || len_o !== 4'd0) begin fails++;
      $display("FAIL col_rec_key got rec=%0b len=%0d exp 0 0", recording_o, len_o); end
    play();
    tests++; if (playing_o !== 1'b0) begin fails++; $display("FAIL col_empty_play got %0b exp 0", playing_o); end
    rec(); press(5); rec(); play(); rec();
    tests++; if (playing_o !== 1'b1 || recording_o !== 1'b0 || keycode_o !== 4'd5) begin fails++;
      $display("FAIL col_play_ignores_rec got play=%0b rec=%0b key=%0d exp 1 0 5", playing_o, recording_o, keycode_o); end
  endtask

  task automatic test_reset_midplay();
    do_reset();
    rec(); press(1); press(2); press(3); press(4); rec(); play(); tick(); tick();
    tests++; if (step_o !== 3'd2 || keycode_o !== 4'd3) begin fails++;
      $display("FAIL mid_pre got step=%0d key=%0d exp 2 3", step_o, keycode_o); end
    rst = 1'b1; #1;
    tests++; if (playing_o !== 1'b0 || step_o !== 3'd0 || len_o !== 4'd0 || keycode_o !== 4'd0) begin fails++;
      $display("FAIL mid_rst got play=%0b step=%0d len=%0d key=%0d exp 0 0 0 0", playing_o, step_o, len_o, keycode_o); end
    rst = 1'b0; #1;
    model_reset();
    play();
    tests++; if (playing_o !== 1'b0 || len_o !== 4'd0) begin fails++;
      $display("FAIL mid_play_after got play=%0b len=%0d exp 0 0", playing_o, len_o); end
  endtask

  task automatic test_random();
    bit e, ke, re, pe, tk;
    int k;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      e  = ($urandom_range(0, 7) != 0);
      k  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      ke = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 11) == 0);
      pe = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 1) == 0);
      if (ke && pe) pe = 1'b0;
      drive(e, k, ke, re, pe, tk);
      tests++; if (keycode_o !== 4'(exp_key(e, k)) || step_o !== 3'((m_mode == 2) ? m_step : 0) ||
                   len_o !== 4'(m_len) || recording_o !== (m_mode == 1) || playing_o !== (m_mode == 2)) begin
        fails++;
        $display("FAIL rand_%0d got key=%0d step=%0d len=%0d rec=%0b play=%0b exp key=%0d step=%0d len=%0d rec=%0b play=%0b",
                 n, keycode_o, step_o, len_o, recording_o, playing_o, exp_key(e, k),
                 (m_mode == 2) ? m_step : 0, m_len, m_mode == 1, m_mode == 2);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_rest();
    test_override();
    test_collisions();
    test_reset_midplay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_step_sequencer
